// File: rtl/fft_sdf_pair_buf_pkg.sv
// Shared types and helpers for the radix-2 SDF stage input buffer.
// Sample/block types use the default pipeline geometry; modules parameterise their own ports.
package fft_pkg;

   localparam int DATA_WIDTH_DEF = 9;
   localparam int LANES_DEF      = 16;
   localparam int DEPTH_DEF      = 16;

   typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

   typedef struct packed {
      sample_t [LANES_DEF-1:0] i;
      sample_t [LANES_DEF-1:0] q;
   } cplx_blk_t;

   // Phase counter width for a frame of 2*depth blocks; never narrower than 1 bit.
   function automatic int ph_width(input int depth);
      return (depth < 1) ? 1 : $clog2(2 * depth);
   endfunction

endpackage

// File: rtl/fft_sdf_pair_buf_if.sv
// Block stream into the pair buffer and operand pairs out to the butterfly.
// master drives the input stream; slave is the buffer.
interface fft_sdf_pair_buf_if #(
   parameter int DATA_WIDTH = 9,
   parameter int DEPTH      = 16,
   parameter int LANES      = 16
);
   localparam int PH_W = fft_pkg::ph_width(DEPTH);

   logic                                    flush;
   logic                                    din_valid;
   logic signed [LANES-1:0][DATA_WIDTH-1:0] din_i;
   logic signed [LANES-1:0][DATA_WIDTH-1:0] din_q;
   logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_a_i;
   logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_a_q;
   logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_b_i;
   logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_b_q;
   logic                                    bufly_enable;
   logic [PH_W-1:0]                         phase;
   logic                                    frame_done;

   modport master (
      output flush, din_valid, din_i, din_q,
      input  dout_a_i, dout_a_q, dout_b_i, dout_b_q, bufly_enable, phase, frame_done
   );

   modport slave (
      input  flush, din_valid, din_i, din_q,
      output dout_a_i, dout_a_q, dout_b_i, dout_b_q, bufly_enable, phase, frame_done
   );

endinterface

// File: rtl/fft_sdf_pair_buf_delay_line.sv
// DEPTH-entry shift line of LANES-wide I/Q blocks; head is the block pushed DEPTH pushes ago.
module fft_delay_line #(
   parameter int DATA_WIDTH = 9,
   parameter int DEPTH      = 16,
   parameter int LANES      = 16
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic                                    push,
   input  logic signed [LANES-1:0][DATA_WIDTH-1:0] din_i,
   input  logic signed [LANES-1:0][DATA_WIDTH-1:0] din_q,
   output logic signed [LANES-1:0][DATA_WIDTH-1:0] head_i,
   output logic signed [LANES-1:0][DATA_WIDTH-1:0] head_q
);

    logic signed [LANES-1:0][DATA_WIDTH-1:0] mem_i [DEPTH];
    logic signed [LANES-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_i[e] <= '0;
                mem_q[e] <= '0;
            end
        end else if (push) begin
            // Entry 0 is the head; the newest block enters at the tail.
            for (int e = 0; e < DEPTH - 1; e++) begin
                mem_i[e] <= mem_i[e+1];
                mem_q[e] <= mem_q[e+1];
            end
            mem_i[DEPTH-1] <= din_i;
            mem_q[DEPTH-1] <= din_q;
        end
    end

    assign head_i = mem_i[0];
    assign head_q = mem_q[0];

endmodule

// File: rtl/fft_sdf_pair_buf.sv
// SDF stage input buffer: delays the first half of each frame and hands registered
// (delayed, current) operand pairs to the butterfly during the second half.
module fft_sdf_pair_buf
   import fft_pkg::*;
#(
   parameter  int DATA_WIDTH = 9,
   parameter  int DEPTH      = 16,
   parameter  int LANES      = 16,
   localparam int PH_W       = ph_width(DEPTH)
) (
   input  logic                clk,
   input  logic                rstn,
   fft_sdf_pair_buf_if.slave   bus
);

    localparam logic [PH_W-1:0] PH_HALF = PH_W'(DEPTH);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DEPTH - 1);

    logic                                    accept;
    logic                                    pair;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] head_i;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] head_q;

    assign accept = bus.din_valid && !bus.flush;
    assign pair   = accept && (bus.phase >= PH_HALF);

    fft_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .LANES      (LANES)
    ) u_line (
        .clk    (clk),
        .rstn   (rstn),
        .push   (accept),
        .din_i  (bus.din_i),
        .din_q  (bus.din_q),
        .head_i (head_i),
        .head_q (head_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.phase        <= '0;
            bus.bufly_enable <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.dout_a_i     <= '0;
            bus.dout_a_q     <= '0;
            bus.dout_b_i     <= '0;
            bus.dout_b_q     <= '0;
        end else if (bus.flush) begin
            // Storage and operands are left as-is; the refill overwrites them.
            bus.phase        <= '0;
            bus.bufly_enable <= 1'b0;
            bus.frame_done   <= 1'b0;
        end else begin
            bus.bufly_enable <= pair;
            bus.frame_done   <= accept && (bus.phase == PH_LAST);
            if (accept) begin
                bus.phase <= (bus.phase == PH_LAST) ? '0 : bus.phase + 1'b1;
            end
            if (pair) begin
                bus.dout_a_i <= head_i;
                bus.dout_a_q <= head_q;
                bus.dout_b_i <= bus.din_i;
                bus.dout_b_q <= bus.din_q;
            end
        end
    end

endmodule

// File: tb/tb_fft_sdf_pair_buf.sv
// Directed bench for fft_sdf_pair_buf: DEPTH=4/LANES=2, default geometry, and DEPTH=1.
module tb_fft_sdf_pair_buf;
    import fft_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // held-operand model for the DEPTH=4 instance (value replicated across lanes)
    int ea_i, ea_q, eb_i, eb_q;

    fft_sdf_pair_buf_if #(.DATA_WIDTH(9), .DEPTH(4),  .LANES(2))  b4 ();
    fft_sdf_pair_buf_if #(.DATA_WIDTH(9), .DEPTH(16), .LANES(16)) b16 ();
    fft_sdf_pair_buf_if #(.DATA_WIDTH(9), .DEPTH(1),  .LANES(2))  b1 ();

    fft_sdf_pair_buf #(.DATA_WIDTH(9), .DEPTH(4),  .LANES(2))  dut4  (.clk(clk), .rstn(rstn), .bus(b4));
    fft_sdf_pair_buf #(.DATA_WIDTH(9), .DEPTH(16), .LANES(16)) dut16 (.clk(clk), .rstn(rstn), .bus(b16));
    fft_sdf_pair_buf #(.DATA_WIDTH(9), .DEPTH(1),  .LANES(2))  dut1  (.clk(clk), .rstn(rstn), .bus(b1));

    function automatic logic [1:0][8:0] blk2(input int v);
        logic [1:0][8:0] r;
        for (int l = 0; l < 2; l++) r[l] = 9'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b4.din_valid  = 1'b0; b4.flush  = 1'b0; b4.din_i  = '0; b4.din_q  = '0;
        b16.din_valid = 1'b0; b16.flush = 1'b0; b16.din_i = '0; b16.din_q = '0;
        b1.din_valid  = 1'b0; b1.flush  = 1'b0; b1.din_i  = '0; b1.din_q  = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        ea_i = 0; ea_q = 0; eb_i = 0; eb_q = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rstn = 1'b0;
        b4.din_valid  = 1'b1; b4.din_i = blk2(7); b4.din_q = blk2(-7);
        b16.din_valid = 1'b1; b16.din_i = '1;
        b1.din_valid  = 1'b1; b1.din_i  = blk2(5);
        repeat (3) tick();
        vectors++;
        if ({b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_dout4: got %0h expected 0", {b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q});
        end
        vectors++;
        if ({b4.bufly_enable, b4.frame_done, b4.phase} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl4: got %0b expected 0", {b4.bufly_enable, b4.frame_done, b4.phase});
        end
        vectors++;
        if ({b16.bufly_enable, b16.frame_done, b16.phase} !== 7'b0 ||
            {b16.dout_a_i, b16.dout_b_q} !== '0) begin
            miscompares++;
            $display("FAIL reset_16: got ctl %0b expected 0", {b16.bufly_enable, b16.frame_done, b16.phase});
        end
        vectors++;
        if ({b1.bufly_enable, b1.frame_done, b1.phase, b1.dout_a_i, b1.dout_b_i} !== '0) begin
            miscompares++;
            $display("FAIL reset_1: got ctl %0b expected 0", {b1.bufly_enable, b1.frame_done, b1.phase});
        end
        rstn = 1'b1;
        b16.din_valid = 1'b0;
        b1.din_valid  = 1'b0;
        tick();
        vectors++;
        if (b4.phase !== 3'd1 || b4.bufly_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_accept: got phase %0d en %0b expected phase 1 en 0", b4.phase, b4.bufly_enable);
        end
        b4.din_valid = 1'b0;
    endtask

    // Eight accepts on the DEPTH=4 instance from phase 0, optionally with two-cycle gaps after pushes 1 and 5.
    task automatic test_frame(input bit gaps, input int base, input string tag);
        int exp_ph;
        for (int k = 0; k < 8; k++) begin
            b4.din_valid = 1'b1;
            b4.din_i = blk2(base + k);
            b4.din_q = blk2(-(base + k));
            tick();
            exp_ph = (k + 1) % 8;
            if (k >= 4) begin
                ea_i = base + k - 4; ea_q = -ea_i;
                eb_i = base + k;     eb_q = -eb_i;
            end
            vectors++;
            if (b4.bufly_enable !== (k >= 4)) begin
                miscompares++;
                $display("FAIL %s_en k=%0d: got %0b expected %0b", tag, k, b4.bufly_enable, (k >= 4));
            end
            vectors++;
            if (b4.frame_done !== (k == 7)) begin
                miscompares++;
                $display("FAIL %s_fd k=%0d: got %0b expected %0b", tag, k, b4.frame_done, (k == 7));
            end
            vectors++;
            if (b4.phase !== 3'(exp_ph)) begin
                miscompares++;
                $display("FAIL %s_phase k=%0d: got %0d expected %0d", tag, k, b4.phase, exp_ph);
            end
            vectors++;
            if ({b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q} !==
                {blk2(ea_i), blk2(ea_q), blk2(eb_i), blk2(eb_q)}) begin
                miscompares++;
                $display("FAIL %s_data k=%0d: got %0h expected %0h", tag, k,
                         {b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q},
                         {blk2(ea_i), blk2(ea_q), blk2(eb_i), blk2(eb_q)});
            end
            if (gaps && (k == 1 || k == 5)) begin
                for (int g = 0; g < 2; g++) begin
                    b4.din_valid = 1'b0;
                    b4.din_i = blk2(77);
                    b4.din_q = blk2(-77);
                    tick();
                    vectors++;
                    if ({b4.bufly_enable, b4.frame_done} !== 2'b00 || b4.phase !== 3'(exp_ph)) begin
                        miscompares++;
                        $display("FAIL %s_gap_ctl k=%0d: got en %0b fd %0b phase %0d expected 0 0 %0d",
                                 tag, k, b4.bufly_enable, b4.frame_done, b4.phase, exp_ph);
                    end
                    vectors++;
                    if ({b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q} !==
                        {blk2(ea_i), blk2(ea_q), blk2(eb_i), blk2(eb_q)}) begin
                        miscompares++;
                        $display("FAIL %s_gap_hold k=%0d: got %0h expected %0h", tag, k,
                                 {b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q},
                                 {blk2(ea_i), blk2(ea_q), blk2(eb_i), blk2(eb_q)});
                    end
                end
            end
        end
        b4.din_valid = 1'b0;
    endtask

    task automatic test_single_frame();
        do_reset();
        test_frame(1'b0, 0, "frame");
    endtask

    task automatic test_gaps();
        do_reset();
        test_frame(1'b1, 0, "gaps");
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            b4.din_valid = 1'b1;
            b4.din_i = blk2(k);
            b4.din_q = blk2(-k);
            tick();
        end
        ea_i = 0; ea_q = 0; eb_i = 4; eb_q = -4;
        vectors++;
        if (b4.phase !== 3'd5) begin
            miscompares++;
            $display("FAIL flush_pre_phase: got %0d expected 5", b4.phase);
        end
        b4.flush = 1'b1;
        b4.din_i = blk2(99);
        b4.din_q = blk2(-99);
        tick();
        b4.flush = 1'b0;
        b4.din_valid = 1'b0;
        vectors++;
        if ({b4.bufly_enable, b4.frame_done, b4.phase} !== 5'b0) begin
            miscompares++;
            $display("FAIL flush_ctl: got %0b expected 0", {b4.bufly_enable, b4.frame_done, b4.phase});
        end
        vectors++;
        if ({b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q} !==
            {blk2(0), blk2(0), blk2(4), blk2(-4)}) begin
            miscompares++;
            $display("FAIL flush_hold: got %0h expected %0h",
                     {b4.dout_a_i, b4.dout_a_q, b4.dout_b_i, b4.dout_b_q},
                     {blk2(0), blk2(0), blk2(4), blk2(-4)});
        end
        test_frame(1'b0, 10, "flush_refill");
    endtask

    task automatic test_back_to_back();
        cplx_blk_t hist [96];
        int p;
        int pairs_seen = 0;
        int done_seen  = 0;
        do_reset();
        for (int n = 0; n < 96; n++) begin
            for (int l = 0; l < 16; l++) begin
                hist[n].i[l] = ($urandom_range(0, 1) == 1) ? 9'sd255 : -9'sd256;
                hist[n].q[l] = ($urandom_range(0, 1) == 1) ? 9'sd255 : -9'sd256;
            end
            b16.din_valid = 1'b1;
            b16.din_i = hist[n].i;
            b16.din_q = hist[n].q;
            tick();
            p = n % 32;
            if (b16.bufly_enable === 1'b1) pairs_seen++;
            if (b16.frame_done === 1'b1) done_seen++;
            vectors++;
            if ({b16.bufly_enable, b16.frame_done, b16.phase} !== {(p >= 16), (p == 31), 5'((n + 1) % 32)}) begin
                miscompares++;
                $display("FAIL b2b_ctl n=%0d: got en %0b fd %0b phase %0d expected %0b %0b %0d", n,
                         b16.bufly_enable, b16.frame_done, b16.phase, (p >= 16), (p == 31), (n + 1) % 32);
            end
            if (p >= 16) begin
                vectors++;
                if ({b16.dout_a_i, b16.dout_a_q, b16.dout_b_i, b16.dout_b_q} !==
                    {hist[n-16].i, hist[n-16].q, hist[n].i, hist[n].q}) begin
                    miscompares++;
                    $display("FAIL b2b_data n=%0d: got a_i %0h b_i %0h expected a_i %0h b_i %0h", n,
                             b16.dout_a_i, b16.dout_b_i, hist[n-16].i, hist[n].i);
                end
            end
        end
        b16.din_valid = 1'b0;
        vectors++;
        if (pairs_seen != 48) begin
            miscompares++;
            $display("FAIL b2b_pair_count: got %0d expected 48", pairs_seen);
        end
        vectors++;
        if (done_seen != 3) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d expected 3", done_seen);
        end
    endtask

    task automatic test_depth1();
        int vals [4] = '{10, 20, 30, 40};
        int ha = 0;
        int hb = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b1.din_valid = 1'b1;
            b1.din_i = blk2(vals[k]);
            b1.din_q = blk2(-vals[k]);
            tick();
            if (k % 2 == 1) begin
                ha = vals[k-1];
                hb = vals[k];
            end
            vectors++;
            if ({b1.bufly_enable, b1.frame_done, b1.phase} !== {(k % 2 == 1), (k % 2 == 1), 1'((k + 1) % 2)}) begin
                miscompares++;
                $display("FAIL d1_ctl k=%0d: got %0b expected %0b", k,
                         {b1.bufly_enable, b1.frame_done, b1.phase}, {(k % 2 == 1), (k % 2 == 1), 1'((k + 1) % 2)});
            end
            vectors++;
            if ({b1.dout_a_i, b1.dout_a_q, b1.dout_b_i, b1.dout_b_q} !==
                {blk2(ha), blk2(-ha), blk2(hb), blk2(-hb)}) begin
                miscompares++;
                $display("FAIL d1_data k=%0d: got %0h expected %0h", k,
                         {b1.dout_a_i, b1.dout_a_q, b1.dout_b_i, b1.dout_b_q},
                         {blk2(ha), blk2(-ha), blk2(hb), blk2(-hb)});
            end
        end
        b1.din_valid = 1'b0;
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_frame();
        test_gaps();
        test_flush();
        test_back_to_back();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
